// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding and
// the quotient reported when a requester divides by zero.
package div_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    REARM
  } state_t;

  localparam int MAX_DATA_WIDTH = 64;
  localparam logic [MAX_DATA_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer, wrapping around the request vector.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_valid
);

  int idx;

  // Scan from the farthest offset back to the pointer so the nearest hit wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant     = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one sequential divider core among NUM_REQ
// requesters; re-arms the core through div_rst_n after every job.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_quotient,
  output logic [DATA_WIDTH-1:0]         rsp_remainder,
  output logic                          rsp_dbz,
  output logic                          busy,
  output logic                          div_rst_n,
  output logic                          div_start,
  output logic [DATA_WIDTH-1:0]         div_dividend,
  output logic [DATA_WIDTH-1:0]         div_divisor,
  input  logic [DATA_WIDTH-1:0]         div_quotient,
  input  logic [DATA_WIDTH-1:0]         div_remainder,
  input  logic                          div_done
);

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       grant;
  logic [ID_W-1:0]       next_ptr;
  logic [ID_W-1:0]       id_q;
  logic                  any_valid;
  logic                  used_core;
  logic                  rearm_n;
  logic                  dbz_q;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] sel_dividend;
  logic [DATA_WIDTH-1:0] sel_divisor;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .any_valid(any_valid)
  );

  // Accept is combinational so the grant handshake completes in the IDLE cycle.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    req_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_dividend = req_dividend[i*DATA_WIDTH +: DATA_WIDTH];
        sel_divisor  = req_divisor[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = rst_n && (state == IDLE) && any_valid;
      end
    end
  end

  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      used_core  <= 1'b0;
      rearm_n    <= 1'b1;
      dbz_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      rearm_n <= 1'b1;
      case (state)
        IDLE: begin
          if (any_valid) begin
            id_q       <= grant;
            rr_ptr     <= next_ptr;
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            if (sel_divisor == '0) begin
              quot_q    <= DBZ_QUOTIENT[DATA_WIDTH-1:0];
              rem_q     <= sel_dividend;
              dbz_q     <= 1'b1;
              used_core <= 1'b0;
              state     <= RESP;
            end else begin
              dbz_q     <= 1'b0;
              used_core <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_done) begin
            quot_q <= div_quotient;
            rem_q  <= div_remainder;
            state  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (used_core) begin
              rearm_n <= 1'b0;
              state   <= REARM;
            end else begin
              state <= IDLE;
            end
          end
        end
        REARM:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign div_start     = (state == ISSUE);
  assign rsp_valid     = (state == RESP);
  assign rsp_id        = id_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_dbz       = dbz_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign div_rst_n     = rst_n & rearm_n;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: a behavioural divider core, a cycle-level model of the
// scheduling and latency rules, and directed jobs with literal expectations.
module tb_div_arbiter;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dividend;
  logic [N*DW-1:0] req_divisor;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_quotient;
  logic [DW-1:0]   rsp_remainder;
  logic            rsp_dbz;
  logic            busy;
  logic            div_rst_n;
  logic            div_start;
  logic [DW-1:0]   div_dividend;
  logic [DW-1:0]   div_divisor;
  logic [DW-1:0]   div_quotient;
  logic [DW-1:0]   div_remainder;
  logic            div_done;

  div_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
    .busy(busy), .div_rst_n(div_rst_n), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done)
  );

  // Divider core stand-in: done appears DW+1 cycles after the start cycle and
  // stays high until div_rst_n is pulsed.
  int            c_cnt;
  logic [DW-1:0] c_a, c_b;
  always @(posedge clk or negedge div_rst_n) begin
    if (!div_rst_n) begin
      c_cnt <= 0; div_done <= 1'b0; div_quotient <= '0; div_remainder <= '0;
      c_a <= '0; c_b <= '0;
    end else if (div_start) begin
      c_cnt <= DW; c_a <= div_dividend; c_b <= div_divisor; div_done <= 1'b0;
    end else if (c_cnt == 1) begin
      c_cnt <= 0;
      div_done <= 1'b1;
      div_quotient  <= (c_b != 0) ? c_a / c_b : '1;
      div_remainder <= (c_b != 0) ? c_a % c_b : c_a;
    end else if (c_cnt > 1) begin
      c_cnt <= c_cnt - 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model state
  bit            m_busy, m_used, m_hs_done, lat_seen;
  int            m_ptr, m_grant, m_start_at, m_resp_at, m_until, m_rearm_at, m_lat, m_id;
  logic [DW-1:0] m_a, m_b, m_q, m_r;
  logic          m_dbz;
  logic [N-1:0]  gnt_seen;
  int            start_cnt = 0;
  int            rearm_cnt = 0;
  int lg_id[$], lg_q[$], lg_r[$], lg_dbz[$], lg_lat[$];

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    int g, idx;
    bit e_rv;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_q", 32'(rsp_quotient), 0);
      chk("rst_rsp_r", 32'(rsp_remainder), 0);
      chk("rst_rsp_dbz", 32'(rsp_dbz), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_div_rst_n", 32'(div_rst_n), 0);
      chk("rst_div_start", 32'(div_start), 0);
      chk("rst_div_dividend", 32'(div_dividend), 0);
      chk("rst_div_divisor", 32'(div_divisor), 0);
      m_busy = 0; m_ptr = 0; m_rearm_at = -1; lat_seen = 0; gnt_seen = '0;
    end else begin
      if (!div_rst_n) rearm_cnt++;
      if (div_start) start_cnt++;
      e_ready = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) e_ready[g] = 1'b1;
      e_rv = m_busy && !m_hs_done && (cyc >= m_resp_at);
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("div_start", 32'(div_start), 32'(m_busy && m_used && cyc == m_start_at));
      chk("div_rst_n", 32'(div_rst_n), 32'(!(m_busy && cyc == m_rearm_at)));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_rv) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_quotient", 32'(rsp_quotient), 32'(m_q));
        chk("rsp_remainder", 32'(rsp_remainder), 32'(m_r));
        chk("rsp_dbz", 32'(rsp_dbz), 32'(m_dbz));
      end
      if (m_busy && m_used && cyc >= m_start_at && cyc < m_resp_at) begin
        chk("div_dividend", 32'(div_dividend), 32'(m_a));
        chk("div_divisor", 32'(div_divisor), 32'(m_b));
      end
      if (m_busy && rsp_valid && !lat_seen) begin
        lat_seen = 1;
        m_lat = cyc - m_grant;
      end
      if (e_rv && rsp_ready) begin
        lg_id.push_back(int'(rsp_id));
        lg_q.push_back(int'(rsp_quotient));
        lg_r.push_back(int'(rsp_remainder));
        lg_dbz.push_back(int'(rsp_dbz));
        lg_lat.push_back(lat_seen ? m_lat : -1);
        m_hs_done = 1;
        m_until = m_used ? cyc + 1 : cyc;
        m_rearm_at = m_used ? cyc + 1 : -1;
      end
      if (m_busy && m_hs_done && cyc >= m_until) m_busy = 0;
      gnt_seen = req_valid & req_ready;
      if (g >= 0) begin
        m_busy = 1; m_hs_done = 0; lat_seen = 0;
        m_grant = cyc; m_id = g;
        m_a = req_dividend[g*DW +: DW];
        m_b = req_divisor[g*DW +: DW];
        m_used = (m_b != 0);
        m_q = m_used ? m_a / m_b : '1;
        m_r = m_used ? m_a % m_b : m_a;
        m_dbz = !m_used;
        m_start_at = cyc + 1;
        m_resp_at = m_used ? cyc + DW + 3 : cyc + 1;
        m_until = 32'h7fff_ffff;
        m_rearm_at = -1;
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gnt_seen;
  endtask

  task automatic issue(input int i, input int a, input int b);
    req_dividend[i*DW +: DW] = DW'(a);
    req_divisor[i*DW +: DW]  = DW'(b);
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsps(input int n);
    int budget;
    budget = 0;
    while (lg_id.size() < n && budget < 60 * 8) begin
      step();
      budget++;
    end
    if (lg_id.size() < n) chk("rsp_timeout", 32'(lg_id.size()), 32'(n));
  endtask

  task automatic exp_rsp(input int k, input int id, input int q, input int r, input int dbz);
    if (k < lg_id.size()) begin
      chk($sformatf("lit%0d_id", k), 32'(lg_id[k]), 32'(id));
      chk($sformatf("lit%0d_q", k), 32'(lg_q[k]), 32'(q));
      chk($sformatf("lit%0d_r", k), 32'(lg_r[k]), 32'(r));
      chk($sformatf("lit%0d_dbz", k), 32'(lg_dbz[k]), 32'(dbz));
    end else begin
      chk($sformatf("lit%0d_missing", k), 32'(lg_id.size()), 32'(k + 1));
    end
  endtask

  initial begin
    int s0, r0, hold;
    rst_n = 1'b0; req_valid = '0; req_dividend = '0; req_divisor = '0; rsp_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single job: 100/7 from requester 1
    s0 = start_cnt; r0 = rearm_cnt;
    issue(1, 100, 7);
    wait_rsps(1);
    step(); step();
    exp_rsp(0, 1, 14, 2, 0);
    chk("t1_latency", 32'(lg_lat[0]), 19);
    chk("t1_rearm_cycles", 32'(rearm_cnt - r0), 1);
    chk("t1_starts", 32'(start_cnt - s0), 1);

    // Round-robin order from reset, then pointer wrap behaviour
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    for (int i = 0; i < N; i++) issue(i, (i + 1) * 1000, 3);
    wait_rsps(5);
    exp_rsp(1, 0, 333, 1, 0);
    exp_rsp(2, 1, 666, 2, 0);
    exp_rsp(3, 2, 1000, 0, 0);
    exp_rsp(4, 3, 1333, 1, 0);
    repeat (3) step();
    issue(0, 10, 3); issue(3, 20, 3);
    wait_rsps(7);
    exp_rsp(5, 0, 3, 1, 0);
    exp_rsp(6, 3, 6, 2, 0);
    repeat (3) step();
    issue(2, 30, 3);
    wait_rsps(8);
    exp_rsp(7, 2, 10, 0, 0);
    repeat (3) step();
    issue(0, 40, 6); issue(3, 50, 7);
    wait_rsps(10);
    exp_rsp(8, 3, 7, 1, 0);
    exp_rsp(9, 0, 6, 4, 0);
    repeat (3) step();

    // Divide by zero bypasses the core
    s0 = start_cnt; r0 = rearm_cnt;
    issue(2, 'h1234, 0);
    wait_rsps(11);
    step(); step();
    exp_rsp(10, 2, 'hFFFF, 'h1234, 1);
    chk("t3_latency", 32'(lg_lat[10]), 1);
    chk("t3_starts", 32'(start_cnt - s0), 0);
    chk("t3_rearm_cycles", 32'(rearm_cnt - r0), 0);

    // Response back-pressure with a competing request
    s0 = start_cnt; r0 = rearm_cnt;
    rsp_ready = 1'b0;
    issue(0, 50000, 123);
    hold = 0;
    while (!rsp_valid && hold < 40) begin step(); hold++; end
    chk("t4_rsp_valid_seen", 32'(rsp_valid), 1);
    issue(1, 9, 4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_q", 32'(rsp_quotient), 406);
      chk("t4_hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    wait_rsps(13);
    step(); step();
    exp_rsp(11, 0, 406, 62, 0);
    exp_rsp(12, 1, 2, 1, 0);
    chk("t4_rearm_cycles", 32'(rearm_cnt - r0), 2);
    chk("t4_starts", 32'(start_cnt - s0), 2);

    // Reset while the core is working
    issue(0, 1000, 10);
    repeat (6) step();
    chk("t5_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_div_rst_n", 32'(div_rst_n), 0);
    chk("t5_div_start", 32'(div_start), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    issue(0, 65535, 255);
    wait_rsps(14);
    exp_rsp(13, 0, 257, 0, 0);

    // Operand boundaries
    step(); step();
    issue(3, 5, 9);
    wait_rsps(15);
    step(); step();
    issue(1, 65535, 1);
    wait_rsps(16);
    step(); step();
    issue(0, 0, 7);
    wait_rsps(17);
    exp_rsp(14, 3, 0, 5, 0);
    exp_rsp(15, 1, 65535, 0, 0);
    exp_rsp(16, 0, 0, 0, 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
